// File: rtl/objects_mux_pkg.sv
// rtl/objects_mux_pkg.sv - shared constants and pair-index helpers for the layer compositor
package objects_mux_pkg;

  localparam int MAX_LAYERS = 8;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Flat index of unordered pair (i,j), i<j, enumerated row by row.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// rtl/layer_priority_enc.sv - combinational lowest-index-first priority encoder
module layer_priority_enc #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan downward so the lowest requesting index is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/objects_mux_n.sv
// rtl/objects_mux_n.sv - N-layer priority pixel compositor with per-frame pairwise collision capture
module objects_mux_n
  import objects_mux_pkg::*;
#(
  parameter  int               NUM_LAYERS  = 4,
  parameter  int               RGB_W       = 8,
  parameter  logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
  localparam int               NUM_PAIRS   = num_pairs(NUM_LAYERS),
  localparam int               IDX_W       = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            backGroundRGB,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        winnerValid,
  output logic [IDX_W-1:0]            winnerIdx,
  output logic [NUM_PAIRS-1:0]        collisionFrame,
  output logic                        collisionPulse
);

  if (NUM_LAYERS < 2 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_layers
    $error("objects_mux_n: NUM_LAYERS out of range");
  end

  logic [NUM_LAYERS-1:0]       eff_req;
  logic [NUM_PAIRS-1:0]        pair_hit;
  logic [NUM_LAYERS-1:0]       eff_s1;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_s1;
  logic [RGB_W-1:0]            bg_s1;
  logic [NUM_PAIRS-1:0]        pair_s1;
  logic                        sof_s1;
  logic [NUM_PAIRS-1:0]        coll_acc;
  logic [NUM_PAIRS-1:0]        coll_base;
  logic                        win_found;
  logic [IDX_W-1:0]            win_idx;

  // A colour-keyed pixel counts as no request, for both drawing and collisions.
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_eff
    assign eff_req[i] = drawReq[i] & layerEnable[i] &
                        (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_pair_i
    for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_pair_j
      assign pair_hit[pair_idx(i, j, NUM_LAYERS)] = eff_req[i] & eff_req[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eff_s1  <= '0;
      rgb_s1  <= '0;
      bg_s1   <= '0;
      pair_s1 <= '0;
      sof_s1  <= 1'b0;
    end else begin
      eff_s1  <= eff_req;
      rgb_s1  <= layerRGB;
      bg_s1   <= backGroundRGB;
      pair_s1 <= pair_hit;
      sof_s1  <= startOfFrame;
    end
  end

  layer_priority_enc #(.N(NUM_LAYERS)) u_enc (
    .req   (eff_s1),
    .found (win_found),
    .idx   (win_idx)
  );

  // Hits on the frame-start pixel belong to the new frame, so they are never masked by the old one.
  assign coll_base = sof_s1 ? '0 : coll_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RGBOut         <= '0;
      winnerValid    <= 1'b0;
      winnerIdx      <= '0;
      collisionFrame <= '0;
      collisionPulse <= 1'b0;
      coll_acc       <= '0;
    end else begin
      RGBOut         <= win_found ? rgb_s1[win_idx*RGB_W +: RGB_W] : bg_s1;
      winnerValid    <= win_found;
      winnerIdx      <= win_idx;
      collisionPulse <= |(pair_s1 & ~coll_base);
      if (sof_s1) begin
        collisionFrame <= coll_acc;
        coll_acc       <= pair_s1;
      end else begin
        coll_acc       <= coll_acc | pair_s1;
      end
    end
  end

endmodule

// File: tb/tb_objects_mux_n.sv
// tb/tb_objects_mux_n.sv - table-driven directed bench for objects_mux_n
module tb_objects_mux_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [3:0]  drawReq;
  logic [31:0] layerRGB;
  logic [3:0]  layerEnable;
  logic [7:0]  backGroundRGB;
  logic [7:0]  RGBOut;
  logic        winnerValid;
  logic [1:0]  winnerIdx;
  logic [5:0]  collisionFrame;
  logic        collisionPulse;

  int n_vec = 0;
  int n_bad = 0;

  objects_mux_n #(.NUM_LAYERS(4), .RGB_W(8), .TRANSPARENT(8'hFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .drawReq        (drawReq),
    .layerRGB       (layerRGB),
    .layerEnable    (layerEnable),
    .backGroundRGB  (backGroundRGB),
    .RGBOut         (RGBOut),
    .winnerValid    (winnerValid),
    .winnerIdx      (winnerIdx),
    .collisionFrame (collisionFrame),
    .collisionPulse (collisionPulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sof;
    logic [3:0]  req;
    logic [31:0] rgb;
    logic [3:0]  en;
    logic [7:0]  bg;
    logic [7:0]  e_rgb;
    logic        e_valid;
    logic [1:0]  e_idx;
    logic        e_pulse;
    logic [5:0]  e_frame;
  } vec_t;

  localparam int NV = 20;
  localparam logic [31:0] D = 32'h7AE01C11;  // {R3,R2,R1,R0}
  vec_t vecs [NV];

  function automatic vec_t mk(input logic sof, input logic [3:0] req, input logic [31:0] rgb,
                              input logic [3:0] en, input logic [7:0] bg, input logic [7:0] e_rgb,
                              input logic e_valid, input logic [1:0] e_idx, input logic e_pulse,
                              input logic [5:0] e_frame);
    vec_t v;
    v.sof = sof; v.req = req; v.rgb = rgb; v.en = en; v.bg = bg;
    v.e_rgb = e_rgb; v.e_valid = e_valid; v.e_idx = e_idx; v.e_pulse = e_pulse; v.e_frame = e_frame;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " RGBOut"},         32'(RGBOut),         32'h0);
    check({tag, " winnerValid"},    32'(winnerValid),    32'h0);
    check({tag, " winnerIdx"},      32'(winnerIdx),      32'h0);
    check({tag, " collisionFrame"}, 32'(collisionFrame), 32'h0);
    check({tag, " collisionPulse"}, 32'(collisionPulse), 32'h0);
  endtask

  task automatic drive(input logic sof, input logic [3:0] req, input logic [31:0] rgb,
                       input logic [3:0] en, input logic [7:0] bg);
    startOfFrame = sof; drawReq = req; layerRGB = rgb; layerEnable = en; backGroundRGB = bg;
  endtask

  initial begin
    vecs[0]  = mk(1, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h00);
    vecs[1]  = mk(0, 4'b0110, D,            4'hF, 8'h03, 8'h1C, 1, 1, 1, 6'h00);
    vecs[2]  = mk(0, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h00);
    vecs[3]  = mk(0, 4'b0011, 32'h7AE055FF, 4'hF, 8'h03, 8'h55, 1, 1, 0, 6'h00);
    vecs[4]  = mk(0, 4'b0001, D,            4'hE, 8'h03, 8'h03, 0, 0, 0, 6'h00);
    vecs[5]  = mk(1, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h08);
    vecs[6]  = mk(0, 4'b0101, D,            4'hF, 8'h03, 8'h11, 1, 0, 1, 6'h08);
    vecs[7]  = mk(0, 4'b0101, D,            4'hF, 8'h03, 8'h11, 1, 0, 0, 6'h08);
    vecs[8]  = mk(0, 4'b0101, D,            4'hF, 8'h03, 8'h11, 1, 0, 0, 6'h08);
    vecs[9]  = mk(0, 4'b1010, D,            4'hF, 8'h03, 8'h1C, 1, 1, 1, 6'h08);
    vecs[10] = mk(0, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h08);
    vecs[11] = mk(1, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h12);
    vecs[12] = mk(0, 4'b0011, D,            4'hF, 8'h03, 8'h11, 1, 0, 1, 6'h12);
    vecs[13] = mk(1, 4'b1100, D,            4'hF, 8'h03, 8'hE0, 1, 2, 1, 6'h01);
    vecs[14] = mk(0, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h01);
    vecs[15] = mk(1, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h20);
    vecs[16] = mk(0, 4'b1111, D,            4'hF, 8'h03, 8'h11, 1, 0, 1, 6'h20);
    vecs[17] = mk(0, 4'b0000, D,            4'hF, 8'h5A, 8'h5A, 0, 0, 0, 6'h20);
    vecs[18] = mk(1, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h3F);
    vecs[19] = mk(0, 4'b0000, D,            4'hF, 8'h03, 8'h03, 0, 0, 0, 6'h3F);

    reset = 1'b1;
    drive(0, 4'b0000, D, 4'hF, 8'h03);
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Each negedge: check the row driven two cycles earlier, then drive the next row.
    for (int k = 0; k < NV + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("v%0d RGBOut", k - 2),         32'(RGBOut),         32'(vecs[k-2].e_rgb));
        check($sformatf("v%0d winnerValid", k - 2),    32'(winnerValid),    32'(vecs[k-2].e_valid));
        check($sformatf("v%0d winnerIdx", k - 2),      32'(winnerIdx),      32'(vecs[k-2].e_idx));
        check($sformatf("v%0d collisionPulse", k - 2), 32'(collisionPulse), 32'(vecs[k-2].e_pulse));
        check($sformatf("v%0d collisionFrame", k - 2), 32'(collisionFrame), 32'(vecs[k-2].e_frame));
      end
      if (k < NV) drive(vecs[k].sof, vecs[k].req, vecs[k].rgb, vecs[k].en, vecs[k].bg);
      else        drive(0, 4'b0000, D, 4'hF, 8'h03);
    end

    // Mid-frame reset with a live accumulator and RGBOut=1C.
    @(negedge clk) drive(1, 4'b0000, D, 4'hF, 8'h03);
    @(negedge clk) drive(0, 4'b0110, D, 4'hF, 8'h03);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset RGBOut", 32'(RGBOut), 32'h1C);
    #2 reset = 1'b1;
    #1 check_all_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 4'b0001, D, 4'hF, 8'h03);
    @(negedge clk) drive(1, 4'b0000, D, 4'hF, 8'h03);
    @(negedge clk) drive(0, 4'b0000, D, 4'hF, 8'h03);
    check("post-reset RGBOut",      32'(RGBOut),      32'h11);
    check("post-reset winnerValid", 32'(winnerValid), 32'h1);
    @(negedge clk);
    check("post-reset frame",       32'(collisionFrame), 32'h0);
    check("post-reset pulse",       32'(collisionPulse), 32'h0);
    @(negedge clk);
    check("post-reset frame hold",  32'(collisionFrame), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
